// File: rtl/ks_voice_if.sv
// Note-request and voice-bank signals between the sequencer front end and ks_voice_scheduler.
interface ks_voice_if #(
    parameter int NUM_VOICES = 4,
    parameter int LEN_W      = 8
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    // A request transfers on a rising edge where req_valid && req_ready; the front end
    // keeps req_valid and req_len stable until then, and req_ready may drop without a transfer.
    logic                        req_valid;
    logic                        req_ready;
    logic [LEN_W-1:0]            req_len;
    logic [NUM_VOICES-1:0]       voice_release;
    logic [NUM_VOICES-1:0]       voice_trig;
    logic [NUM_VOICES*LEN_W-1:0] voice_len;
    logic [NUM_VOICES-1:0]       voice_busy;
    logic                        alloc_valid;
    logic [IDX_W-1:0]            alloc_voice;
    logic                        alloc_steal;

    modport master (
        output req_valid, req_len, voice_release,
        input  req_ready, voice_trig, voice_len, voice_busy,
               alloc_valid, alloc_voice, alloc_steal
    );

    modport slave (
        input  req_valid, req_len, voice_release,
        output req_ready, voice_trig, voice_len, voice_busy,
               alloc_valid, alloc_voice, alloc_steal
    );
endinterface

// File: rtl/ks_voice_scheduler.sv
// Allocates pluck requests to Karplus-Strong voices and holds each voice's trig for TRIG_HOLD cycles.
// Define KS_VOICE_STEAL_EN to let a request steal a busy voice (round robin) when none is free.
module ks_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int LEN_W      = 8,
    parameter int MIN_LEN    = 4,
    parameter int TRIG_HOLD  = 16
) (
    input  logic       clk,
    input  logic       reset,
    ks_voice_if.slave  bus,
    output logic [1:0] dbg_state_o
);
    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int HOLD_W = $clog2(TRIG_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_TRIG  = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic [LEN_W-1:0]                    len_q, len_d;
    logic [NUM_VOICES-1:0][LEN_W-1:0]    voice_len_q, voice_len_d;
    logic [NUM_VOICES-1:0]               busy_q, busy_d;
    logic [NUM_VOICES-1:0]               trig_q, trig_d;
    logic                                alloc_valid_q, alloc_valid_d;
    logic [IDX_W-1:0]                    alloc_voice_q, alloc_voice_d;
    logic                                alloc_steal_q, alloc_steal_d;
    logic [HOLD_W-1:0]                   hold_q, hold_d;

    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic [IDX_W-1:0] sel_idx;
    logic             steal_sel;
    logic             can_accept;
    logic             req_ready;

    // Scan from the top so the lowest-index free voice is the one left standing.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!busy_q[v]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
        end
    end

`ifdef KS_VOICE_STEAL_EN
    logic [IDX_W-1:0] steal_ptr_q, steal_ptr_d;

    assign can_accept = 1'b1;
    assign steal_sel  = ~free_found;
    assign sel_idx    = free_found ? free_idx : steal_ptr_q;

    always_comb begin
        steal_ptr_d = steal_ptr_q;
        if (state_q == ST_ALLOC && steal_sel) begin
            steal_ptr_d = (steal_ptr_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            steal_ptr_q <= '0;
        end else begin
            steal_ptr_q <= steal_ptr_d;
        end
    end
`else
    assign can_accept = ~&busy_q;
    assign steal_sel  = 1'b0;
    assign sel_idx    = free_idx;
`endif

    assign req_ready = (state_q == ST_IDLE) && !reset && can_accept;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        voice_len_d   = voice_len_q;
        busy_d        = busy_q & ~bus.voice_release;
        trig_d        = trig_q;
        alloc_valid_d = 1'b0;
        alloc_voice_d = alloc_voice_q;
        alloc_steal_d = 1'b0;
        hold_d        = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    len_d   = (bus.req_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : bus.req_len;
                    state_d = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                // The load wins over a release of the same voice in this cycle.
                voice_len_d[sel_idx] = len_q;
                busy_d[sel_idx]      = 1'b1;
                trig_d               = '0;
                trig_d[sel_idx]      = 1'b1;
                alloc_valid_d        = 1'b1;
                alloc_voice_d        = sel_idx;
                alloc_steal_d        = steal_sel;
                hold_d               = HOLD_W'(TRIG_HOLD - 1);
                state_d              = ST_TRIG;
            end
            ST_TRIG: begin
                // A release of the voice being plucked is ignored until the pluck completes.
                busy_d[alloc_voice_q] = 1'b1;
                if (hold_q == '0) begin
                    trig_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                trig_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            len_q         <= LEN_W'(MIN_LEN);
            voice_len_q   <= {NUM_VOICES{LEN_W'(MIN_LEN)}};
            busy_q        <= '0;
            trig_q        <= '0;
            alloc_valid_q <= 1'b0;
            alloc_voice_q <= '0;
            alloc_steal_q <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            voice_len_q   <= voice_len_d;
            busy_q        <= busy_d;
            trig_q        <= trig_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_voice_q <= alloc_voice_d;
            alloc_steal_q <= alloc_steal_d;
            hold_q        <= hold_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.voice_trig  = trig_q;
    assign bus.voice_len   = voice_len_q;
    assign bus.voice_busy  = busy_q;
    assign bus.alloc_valid = alloc_valid_q;
    assign bus.alloc_voice = alloc_voice_q;
    assign bus.alloc_steal = alloc_steal_q;
    assign dbg_state_o     = state_q;
endmodule

// File: doc/ks_voice_scheduler.md
# ks_voice_scheduler

Allocates pluck requests to a bank of Karplus-Strong string voices. Each voice is one delay-line/filter loop. For every accepted note request the block:
- picks a free voice, or steals one when all voices are busy;
- loads that voice's delay-line length;
- drives the voice's trig line high long enough to pass the voice's input debouncer.

It sits between the note/sequencer front end and the per-voice delay-line instances.

## Interface
Parameters:
- NUM_VOICES, 4, number of string voices (2..8)
- LEN_W, 8, delay-line length width
- MIN_LEN, 4, minimum legal length; smaller requests are clamped up to it
- TRIG_HOLD, 16, cycles voice_trig stays high per pluck (≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  note request present
- req_ready  out  1  scheduler can accept a request this cycle
- req_len  in  LEN_W  requested delay-line length (pitch period)
- voice_release  in  NUM_VOICES  one-cycle pulse per voice: note decayed, voice free
- voice_trig  out  NUM_VOICES  per-voice pluck line to the delay-line trig input
- voice_len  out  NUM_VOICES*LEN_W  per-voice length, voice v at bits [v*LEN_W +: LEN_W]
- voice_busy  out  NUM_VOICES  voice allocated and sounding
- alloc_valid  out  1  one-cycle pulse when a voice is loaded
- alloc_voice  out  $clog2(NUM_VOICES)  voice index for alloc_valid; holds last value
- alloc_steal  out  1  with alloc_valid: the allocation stole a busy voice

## Operation
- State machine: IDLE → ALLOC → TRIG → IDLE.
- IDLE:
  - req_ready=1 unless the no-free-voice condition under Configuration applies.
  - A handshake (req_valid && req_ready) latches the clamped length: len_q = max(req_len, MIN_LEN). Then go to ALLOC.
- ALLOC (1 cycle), voice selection:
  - Select the lowest-index voice with voice_busy=0.
  - If all voices are busy, select steal_ptr, then advance steal_ptr modulo NUM_VOICES.
  - Write voice_len[sel]=len_q, set voice_busy[sel]=1, set voice_trig[sel]=1.
  - Pulse alloc_valid and update alloc_voice. Load the hold counter with TRIG_HOLD-1. Go to TRIG.
- TRIG:
  - voice_trig[sel] stays high; the hold counter decrements.
  - At 0, clear voice_trig[sel] and go to IDLE.
  - Only one voice_trig bit is ever high.
- voice_release[v]:
  - Clears voice_busy[v] on the next edge.
  - If this coincides with the ALLOC write of the same voice, the ALLOC write wins and busy stays 1.
  - A release during TRIG for the selected voice is ignored. The pluck is still in progress.
- A stolen voice's voice_len changes at ALLOC. The re-trigger restarts its delay line.
- steal_ptr resets to 0 and advances only on a steal.
- Reset mid-operation: FSM returns to IDLE and any trig in flight drops the next cycle. The pending request is discarded.
- Reset values:
  - voice_trig=0, voice_busy=0, voice_len[v]=MIN_LEN for every voice
  - alloc_valid=0, alloc_voice=0, alloc_steal=0
  - req_ready=0 while reset is asserted, 1 on the first cycle after reset deasserts

## Timing
- Handshake at edge T: ALLOC occupies cycle T+1.
- voice_len, voice_busy, voice_trig and alloc_valid become visible after edge T+1, i.e. in cycle T+2.
- voice_len is valid in the same cycle that trig rises. The downstream block samples length continuously, so no setup slack is needed.
- voice_trig is high for exactly TRIG_HOLD cycles: T+2 .. T+1+TRIG_HOLD.
- req_ready is low from T+1. It is high again in cycle T+2+TRIG_HOLD, so the minimum request spacing is TRIG_HOLD+2 cycles.
- voice_release latency to voice_busy=0 is 1 cycle.

## Configuration
- KS_VOICE_STEAL_EN defined:
  - When all voices are busy, a request is accepted and steals voice steal_ptr.
  - alloc_steal=1 with that alloc_valid.
- KS_VOICE_STEAL_EN undefined:
  - In IDLE, req_ready = ~&voice_busy, so requests stall until a release.
  - alloc_steal is tied to 0 and steal_ptr is not implemented.

## Test plan
- Reset then one request, len=100, TRIG_HOLD=16:
  - voice 0 loaded with 100; voice_trig=4'b0001 for 16 cycles starting 2 cycles after the handshake;
  - alloc_voice=0, voice_busy=4'b0001; req_ready high again 18 cycles after the handshake.
- Clamp: req_len=0, then req_len=3 → voice_len=4 for voices 0 and 1.
- Fill and release: four requests busy all voices; pulse voice_release[2]; a fifth request allocates voice 2 with alloc_steal=0.
- Steal (KS_VOICE_STEAL_EN):
  - with all busy, three requests go to voices 0, 1, 2 in order, each with alloc_steal=1;
  - busy stays 4'b1111.
- No-steal build: with all busy, req_valid held 50 cycles keeps req_ready=0; voice_release[3] → accepted next cycle on voice 3.
- Reset asserted in TRIG mid-hold → voice_trig=0 and voice_busy=0 after one edge; voice_len all equal 4.
